// File: rtl/multicycle_controller.sv
// ============================================================================
//  Module      : multicycle_controller
//  Description : Moore control FSM for a multi-cycle MIPS datapath. Decodes
//                opcode/funct and drives ALU op codes, operand muxes and
//                write strobes; consumes the ALU zero flag for beq.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller #(
    parameter int OP_W = 6,
    parameter int FN_W = 6,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] opcode,
    input  logic [FN_W-1:0] funct,
    input  logic            zero,
    output logic [2:0]      alu_op,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      pc_src,
    output logic            pc_en,
    output logic            iord,
    output logic            mem_write,
    output logic            ir_write,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic [ST_W-1:0] state
);

    typedef enum logic [ST_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        ALUWB    = 4'd7,
        BEQ_EX   = 4'd8,
        ADDI_EX  = 4'd9,
        ADDI_WB  = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FN_W-1:0] FN_AND = 6'b100100;
    localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FN_W-1:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Held as plain bits so out-of-range encodings (12-15) are representable.
    logic [ST_W-1:0] state_q;
    state_t          state_d;

    logic w_pc_write;
    logic w_branch;
    logic w_mem_write;
    logic w_ir_write;
    logic w_reg_write;

    // State register; reset drops straight back to FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode from the registered state.
    always_comb begin
        state_d     = FETCH;
        alu_op      = ALU_ADD;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b01;
        pc_src      = 2'b00;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        w_pc_write  = 1'b0;
        w_branch    = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;

        case (state_q)
            FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                state_d    = DECODE;
            end
            DECODE: begin
                // Branch target computed early while the opcode is decoded.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPE_EX;
                    OP_BEQ:       state_d = BEQ_EX;
                    OP_ADDI:      state_d = ADDI_EX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                w_reg_write = 1'b1;
                mem_to_reg  = 1'b1;
            end
            MEMWR: begin
                iord        = 1'b1;
                w_mem_write = 1'b1;
            end
            RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
                state_d = ALUWB;
            end
            ALUWB: begin
                w_reg_write = 1'b1;
                reg_dst     = 1'b1;
            end
            BEQ_EX: begin
                alu_op    = ALU_SUB;
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                pc_src    = 2'b01;
                w_branch  = 1'b1;
            end
            ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDI_WB;
            end
            ADDI_WB: begin
                w_reg_write = 1'b1;
            end
            JUMP: begin
                pc_src     = 2'b10;
                w_pc_write = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Strobes are gated by rst so nothing writes while reset is held.
    always_comb begin
        pc_en     = (w_pc_write | (w_branch & zero)) & ~rst;
        ir_write  = w_ir_write & ~rst;
        reg_write = w_reg_write & ~rst;
        mem_write = w_mem_write & ~rst;
    end

    assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Directed self-checking bench for multicycle_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    // Output bundle order:
    // alu_op, src_a, src_b, pc_src, pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg
    localparam logic [14:0] V_RESET  = 15'b010_0_01_00_0_0_0_0_0_0_0;
    localparam logic [14:0] V_FETCH  = 15'b010_0_01_00_1_0_0_1_0_0_0;
    localparam logic [14:0] V_DECODE = 15'b010_0_11_00_0_0_0_0_0_0_0;
    localparam logic [14:0] V_MEMADR = 15'b010_1_10_00_0_0_0_0_0_0_0;
    localparam logic [14:0] V_MEMRD  = 15'b010_0_01_00_0_1_0_0_0_0_0;
    localparam logic [14:0] V_MEMWB  = 15'b010_0_01_00_0_0_0_0_1_0_1;
    localparam logic [14:0] V_MEMWR  = 15'b010_0_01_00_0_1_1_0_0_0_0;
    localparam logic [14:0] V_R_ADD  = 15'b010_1_00_00_0_0_0_0_0_0_0;
    localparam logic [14:0] V_R_SUB  = 15'b110_1_00_00_0_0_0_0_0_0_0;
    localparam logic [14:0] V_R_OR   = 15'b001_1_00_00_0_0_0_0_0_0_0;
    localparam logic [14:0] V_R_SLT  = 15'b111_1_00_00_0_0_0_0_0_0_0;
    localparam logic [14:0] V_ALUWB  = 15'b010_0_01_00_0_0_0_0_1_1_0;
    localparam logic [14:0] V_BEQ_T  = 15'b110_1_00_01_1_0_0_0_0_0_0;
    localparam logic [14:0] V_BEQ_NT = 15'b110_1_00_01_0_0_0_0_0_0_0;
    localparam logic [14:0] V_ADDIEX = 15'b010_1_10_00_0_0_0_0_0_0_0;
    localparam logic [14:0] V_ADDIWB = 15'b010_0_01_00_0_0_0_0_1_0_0;
    localparam logic [14:0] V_JUMP   = 15'b010_0_01_10_1_0_0_0_0_0_0;

    logic [14:0] outs;
    assign outs = {alu_op, alu_src_a, alu_src_b, pc_src, pc_en, iord,
                   mem_write, ir_write, reg_write, reg_dst, mem_to_reg};

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance one clock, then check state and the full output bundle.
    task automatic expect_step(input string tag, input logic [3:0] st, input logic [14:0] vec);
        step();
        chk({tag, "_state"}, {28'd0, state}, {28'd0, st});
        chk({tag, "_outs"}, {17'd0, outs}, {17'd0, vec});
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 6'b000000;
        funct  = 6'b100000;
        zero   = 1'b0;
        step();
        step();
        chk("reset_state", {28'd0, state}, 32'd0);
        chk("reset_outs", {17'd0, outs}, {17'd0, V_RESET});

        // Reset released into FETCH, then walk into RTYPE_EX and abort.
        rst = 1'b0;
        #1;
        chk("fetch0_outs", {17'd0, outs}, {17'd0, V_FETCH});
        expect_step("abort_dec", 4'd1, V_DECODE);
        expect_step("abort_rex", 4'd6, V_R_ADD);
        rst = 1'b1;
        #1;
        chk("abort_state", {28'd0, state}, 32'd0);
        chk("abort_outs", {17'd0, outs}, {17'd0, V_RESET});
        step();
        chk("hold_state", {28'd0, state}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_outs", {17'd0, outs}, {17'd0, V_FETCH});

        // First edge after reset lands in DECODE; run an R-type sub.
        funct = 6'b100010;
        expect_step("sub_dec", 4'd1, V_DECODE);
        expect_step("sub_ex", 4'd6, V_R_SUB);
        expect_step("sub_wb", 4'd7, V_ALUWB);
        expect_step("sub_fetch", 4'd0, V_FETCH);

        funct = 6'b100101;
        expect_step("or_dec", 4'd1, V_DECODE);
        expect_step("or_ex", 4'd6, V_R_OR);
        expect_step("or_wb", 4'd7, V_ALUWB);
        expect_step("or_fetch", 4'd0, V_FETCH);

        funct = 6'b101010;
        expect_step("slt_dec", 4'd1, V_DECODE);
        expect_step("slt_ex", 4'd6, V_R_SLT);
        expect_step("slt_wb", 4'd7, V_ALUWB);
        expect_step("slt_fetch", 4'd0, V_FETCH);

        // lw: 0,1,2,3,4,0
        opcode = 6'b100011;
        expect_step("lw_dec", 4'd1, V_DECODE);
        expect_step("lw_adr", 4'd2, V_MEMADR);
        expect_step("lw_rd", 4'd3, V_MEMRD);
        expect_step("lw_wb", 4'd4, V_MEMWB);
        expect_step("lw_fetch", 4'd0, V_FETCH);

        // sw: 0,1,2,5,0
        opcode = 6'b101011;
        expect_step("sw_dec", 4'd1, V_DECODE);
        expect_step("sw_adr", 4'd2, V_MEMADR);
        expect_step("sw_wr", 4'd5, V_MEMWR);
        expect_step("sw_fetch", 4'd0, V_FETCH);

        // beq taken, then not taken
        opcode = 6'b000100;
        zero   = 1'b1;
        expect_step("beqt_dec", 4'd1, V_DECODE);
        expect_step("beqt_ex", 4'd8, V_BEQ_T);
        expect_step("beqt_fetch", 4'd0, V_FETCH);
        zero = 1'b0;
        expect_step("beqn_dec", 4'd1, V_DECODE);
        expect_step("beqn_ex", 4'd8, V_BEQ_NT);
        expect_step("beqn_fetch", 4'd0, V_FETCH);

        // addi and j
        opcode = 6'b001000;
        expect_step("addi_dec", 4'd1, V_DECODE);
        expect_step("addi_ex", 4'd9, V_ADDIEX);
        expect_step("addi_wb", 4'd10, V_ADDIWB);
        expect_step("addi_fetch", 4'd0, V_FETCH);
        opcode = 6'b000010;
        expect_step("j_dec", 4'd1, V_DECODE);
        expect_step("j_jump", 4'd11, V_JUMP);
        expect_step("j_fetch", 4'd0, V_FETCH);

        // Illegal opcode is dropped after DECODE
        opcode = 6'b111111;
        expect_step("ill_dec", 4'd1, V_DECODE);
        expect_step("ill_fetch", 4'd0, V_FETCH);

        // Unused encoding recovers to FETCH
        force dut.state_q = 4'd13;
        #1;
        chk("s13_state", {28'd0, state}, 32'd13);
        chk("s13_outs", {17'd0, outs}, {17'd0, V_RESET});
        release dut.state_q;
        expect_step("s13_fetch", 4'd0, V_FETCH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
